// File: rtl/ntt_addr_gen.sv
// Address sequencer for an in-place radix-2 NTT/INTT: walks every stage's butterflies,
// emits operand/twiddle addresses, and delays them by the butterfly latency for write-back.
module ntt_addr_gen #(
    parameter int LOGN = 8,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic            valid,
    output logic            busy,
    output logic            done,
    output logic [3:0]      stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_idx,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic [1:0]      dbg_state
);

    localparam int              N      = 1 << LOGN;
    localparam logic [LOGN-1:0] B_LAST = LOGN'(N / 2 - 1);
    localparam logic [3:0]      S_LAST = 4'(LOGN - 1);
    localparam logic [3:0]      F_LAST = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [LOGN-1:0] b_q, b_n;
    logic [3:0]      stage_n;
    logic [3:0]      fcnt_q, fcnt_n;
    logic            mode_q, mode_n;

    logic [3:0]      sh;
    logic [LOGN-1:0] h, g, o, a_n, tw_n;

    logic [LAT-1:0]  pipe_en;
    logic [LOGN-1:0] pipe_a [LAT];
    logic [LOGN-1:0] pipe_b [LAT];

    // Handshake: valid is a stall qualifier for the whole block. A read is issued on a
    // cycle with rd_en=1 (RUN and valid); a write is emitted on a cycle with wr_en=1 and
    // valid=1. When valid=0 every counter and the write pipeline hold their value.
    assign rd_en     = (state_q == RUN) && valid && !reset;
    assign dbg_state = state_q;
    assign wr_en     = pipe_en[LAT-1];
    assign wr_addr_a = pipe_a[LAT-1];
    assign wr_addr_b = pipe_b[LAT-1];

    always_comb begin
        state_n = state_q;
        b_n     = b_q;
        stage_n = stage;
        fcnt_n  = fcnt_q;
        mode_n  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    b_n     = '0;
                    stage_n = '0;
                    fcnt_n  = '0;
                    mode_n  = mode;
                end
            end
            RUN: begin
                if (valid) begin
                    if (b_q == B_LAST) begin
                        state_n = FLUSH;
                        fcnt_n  = '0;
                        b_n     = '0;
                    end else begin
                        b_n = b_q + LOGN'(1);
                    end
                end
            end
            FLUSH: begin
                if (valid) begin
                    if (fcnt_q == F_LAST) begin
                        fcnt_n = '0;
                        if (stage == S_LAST) begin
                            state_n = DONE;
                        end else begin
                            state_n = RUN;
                            stage_n = stage + 4'd1;
                            b_n     = '0;
                        end
                    end else begin
                        fcnt_n = fcnt_q + 4'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Addresses are computed for the butterfly that will be current next cycle, so the
    // registered outputs line up with rd_en. sh = log2 of the half-span.
    always_comb begin
        sh   = mode_n ? stage_n : (S_LAST - stage_n);
        h    = LOGN'(1) << sh;
        g    = b_n >> sh;
        o    = b_n & (h - LOGN'(1));
        a_n  = (g << (sh + 4'd1)) | o;
        tw_n = (LOGN'(1) << (S_LAST - sh)) + g;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            b_q       <= '0;
            stage     <= '0;
            fcnt_q    <= '0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            state_q <= state_n;
            b_q     <= b_n;
            stage   <= stage_n;
            fcnt_q  <= fcnt_n;
            mode_q  <= mode_n;
            busy    <= (state_n == RUN) || (state_n == FLUSH);
            done    <= (state_n == DONE);
            if (state_n == RUN) begin
                rd_addr_a <= a_n;
                rd_addr_b <= a_n + h;
                tw_idx    <= tw_n;
            end else begin
                rd_addr_a <= '0;
                rd_addr_b <= '0;
                tw_idx    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_en <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else if (valid) begin
            pipe_en[0] <= rd_en;
            pipe_a[0]  <= rd_addr_a;
            pipe_b[0]  <= rd_addr_b;
            for (int i = 1; i < LAT; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a[i]  <= pipe_a[i-1];
                pipe_b[i]  <= pipe_b[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: a small instance checked against fixed address tables and a
// large instance checked for per-stage address coverage.
module tb_ntt_addr_gen;

    localparam int LOGN  = 3;
    localparam int LAT   = 2;
    localparam int BLOGN = 12;
    localparam int BLAT  = 8;

    typedef struct packed {
        logic [3:0] stage;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] tw;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic reset, start, mode, valid;
    logic busy, done, rd_en, wr_en;
    logic [3:0] stage;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;
    logic [1:0] dbg_state;

    logic b_start, b_mode, b_valid;
    logic big_busy, big_done, big_rd_en, big_wr_en;
    logic [3:0] big_stage;
    logic [BLOGN-1:0] big_rd_a, big_rd_b, big_tw, big_wr_a, big_wr_b;
    logic [1:0] big_state;

    always #5 clk = ~clk;

    ntt_addr_gen #(.LOGN(LOGN), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .valid(valid),
        .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .dbg_state(dbg_state)
    );

    ntt_addr_gen #(.LOGN(BLOGN), .LAT(BLAT)) dut_big (
        .clk(clk), .reset(reset), .start(b_start), .mode(b_mode), .valid(b_valid),
        .busy(big_busy), .done(big_done), .stage(big_stage), .rd_en(big_rd_en),
        .rd_addr_a(big_rd_a), .rd_addr_b(big_rd_b), .tw_idx(big_tw),
        .wr_en(big_wr_en), .wr_addr_a(big_wr_a), .wr_addr_b(big_wr_b),
        .dbg_state(big_state)
    );

    // ---------------- scoreboard state ----------------
    logic [12:0] exp_q[$];
    logic [5:0]  wr_q[$];
    int          wr_vi_q[$];
    vec_t        ntt_tab[12];
    vec_t        intt_tab[12];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, vcnt = 0, rd_cnt = 0, wr_cnt = 0, first_rd = -1;
    int done_cnt = 0, done_exp = 0;
    bit chk_lat = 1'b0;
    logic [3:0] last_stage = 4'hf;

    bit [4095:0] seen [12];
    int hits [12];
    int big_dup = 0, big_tw_zero = 0, big_stage_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
    endtask

    task automatic mon_small();
        if (!reset) begin
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (stage != last_stage) begin
                    check("raw_order", wr_cnt, rd_cnt);
                    last_stage = stage;
                end
                check("busy_in_run", busy, 1);
                if (exp_q.size() == 0) fail_now("rd_unexpected");
                else check("rd_vector", {stage, rd_addr_a, rd_addr_b, tw_idx}, exp_q.pop_front());
                rd_cnt++;
                wr_vi_q.push_back(vcnt + LAT);
            end
            if (wr_en && valid) begin
                if (wr_q.size() == 0 || wr_vi_q.size() == 0) fail_now("wr_unexpected");
                else begin
                    check("wr_addr", {wr_addr_a, wr_addr_b}, wr_q.pop_front());
                    check("wr_latency", vcnt, wr_vi_q.pop_front());
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("busy_in_done", busy, 0);
                if (chk_lat) check("done_latency", cyc - first_rd, 18);
            end
            if (valid) vcnt++;
        end
    endtask

    task automatic mon_big();
        int s;
        if (!reset && big_rd_en) begin
            s = int'(big_stage);
            if (s > BLOGN - 1) big_stage_bad++;
            else begin
                if (seen[s][big_rd_a]) big_dup++;
                if (seen[s][big_rd_b]) big_dup++;
                seen[s][big_rd_a] = 1'b1;
                seen[s][big_rd_b] = 1'b1;
                hits[s] += 2;
            end
            if (big_tw == '0) big_tw_zero++;
        end
    endtask

    // One clock period: inputs stay fixed from just after a rising edge to the next one.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        mon_small();
        mon_big();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_expected(input bit m);
        vec_t v;
        exp_q.delete();
        wr_q.delete();
        wr_vi_q.delete();
        for (int i = 0; i < 12; i++) begin
            v = m ? intt_tab[i] : ntt_tab[i];
            exp_q.push_back(v);
            wr_q.push_back({v.a, v.b});
        end
        rd_cnt = 0; wr_cnt = 0; first_rd = -1; vcnt = 0; last_stage = 4'hf;
    endtask

    task automatic run_transform(input bit m, input bit rnd, input bit poke_run, input bit poke_done);
        bit got;
        got = 1'b0;
        load_expected(m);
        chk_lat = !rnd;
        start = 1'b1; mode = m; valid = 1'b1;
        cycle();
        start = 1'b0;
        done_exp++;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                start = poke_done; mode = ~m; valid = 1'b1;
                cycle();
                start = 1'b0;
                got = 1'b1;
                break;
            end
            valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = poke_run && (k == 2 || k == 7);
            mode  = 1'($urandom_range(0, 1));
            cycle();
        end
        start = 1'b0;
        chk_lat = 1'b0;
        if (!got) fail_now("done_timeout");
        check("sb_rd_drained", exp_q.size(), 0);
        check("sb_wr_drained", wr_q.size(), 0);
        valid = 1'b1;
        repeat (4) cycle();
        check("idle_after_done", dbg_state, 0);
        check("one_done_per_start", done_cnt, done_exp);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_big(input bit m);
        bit got;
        got = 1'b0;
        for (int s = 0; s < 12; s++) begin
            seen[s] = '0;
            hits[s] = 0;
        end
        big_dup = 0; big_tw_zero = 0; big_stage_bad = 0;
        b_start = 1'b1; b_mode = m; b_valid = 1'b1;
        cycle();
        b_start = 1'b0;
        for (int k = 0; k < 26000; k++) begin
            if (big_done) begin
                got = 1'b1;
                break;
            end
            cycle();
        end
        cycle();
        if (!got) fail_now("big_done_timeout");
        for (int s = 0; s < 12; s++) check($sformatf("big_cover_s%0d", s), hits[s], 4096);
        check("big_dup", big_dup, 0);
        check("big_tw_zero", big_tw_zero, 0);
        check("big_stage_range", big_stage_bad, 0);
    endtask

    function automatic vec_t mk(input int s, input int a, input int b, input int tw);
        vec_t v;
        v.stage = 4'(s); v.a = 3'(a); v.b = 3'(b); v.tw = 3'(tw);
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bit found;
        ntt_tab = '{mk(0,0,4,1), mk(0,1,5,1), mk(0,2,6,1), mk(0,3,7,1),
                    mk(1,0,2,2), mk(1,1,3,2), mk(1,4,6,3), mk(1,5,7,3),
                    mk(2,0,1,4), mk(2,2,3,5), mk(2,4,5,6), mk(2,6,7,7)};
        intt_tab = '{mk(0,0,1,4), mk(0,2,3,5), mk(0,4,5,6), mk(0,6,7,7),
                     mk(1,0,2,2), mk(1,1,3,2), mk(1,4,6,3), mk(1,5,7,3),
                     mk(2,0,4,1), mk(2,1,5,1), mk(2,2,6,1), mk(2,3,7,1)};

        // Reset with start and valid asserted: reset must win.
        reset = 1'b1; start = 1'b1; mode = 1'b0; valid = 1'b1;
        b_start = 1'b0; b_mode = 1'b0; b_valid = 1'b1;
        cycle();
        cycle();
        check("reset_outputs", {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
                                wr_en, wr_addr_a, wr_addr_b, dbg_state}, 0);
        reset = 1'b0; start = 1'b0;
        cycle();
        check("reset_priority_state", dbg_state, 0);

        run_transform(1'b0, 1'b0, 1'b0, 1'b0);   // NTT, valid high
        run_transform(1'b1, 1'b0, 1'b0, 1'b0);   // INTT, valid high
        run_transform(1'b0, 1'b1, 1'b0, 1'b0);   // NTT, random stalls
        run_transform(1'b1, 1'b1, 1'b0, 1'b0);   // INTT, random stalls
        run_transform(1'b0, 1'b0, 1'b1, 1'b1);   // stray starts in RUN and DONE

        // Abort at stage 1, butterfly 2, then restart from scratch.
        load_expected(1'b0);
        start = 1'b1; mode = 1'b0; valid = 1'b1;
        cycle();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dbg_state == 2'd1 && stage == 4'd1 && rd_addr_a == 3'd4 && rd_addr_b == 3'd6) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        if (!found) fail_now("abort_point_reached");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("abort_outputs", {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
                                wr_en, wr_addr_a, wr_addr_b, dbg_state}, 0);
        run_transform(1'b0, 1'b0, 1'b0, 1'b0);

        run_big(1'b0);
        run_big(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 Parameter LOGN, default 8, log2 of ring size N; legal 2..12.
REQ-002 Parameter LAT, default 3, butterfly-unit latency in advancing cycles; legal 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a full transform.
REQ-006 mode  input  1  0 = NTT (Cooley-Tukey, span shrinking); 1 = INTT (Gentleman-Sande, span growing); sampled with start.
REQ-007 valid  input  1  advance qualifier; 0 freezes counters and write pipeline.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  one-cycle pulse at transform completion.
REQ-010 stage  output  4  current stage index s, 0..LOGN-1.
REQ-011 rd_en  output  1  read addresses valid this cycle.
REQ-012 rd_addr_a / rd_addr_b  output  LOGN each  butterfly operand addresses.
REQ-013 tw_idx  output  LOGN  twiddle-table index for the current butterfly.
REQ-014 wr_en  output  1  write-back addresses valid this cycle.
REQ-015 wr_addr_a / wr_addr_b  output  LOGN each  write-back addresses.

Function
REQ-016 States IDLE, RUN, FLUSH, DONE; reset enters IDLE.
REQ-017 IDLE -> RUN on start; mode latched; stage=0; butterfly counter b=0.
REQ-018 start while not in IDLE is ignored; mode changes mid-transform are ignored.
REQ-019 Half-span h: NTT h = N>>(s+1); INTT h = 1<<s.
REQ-020 Per butterfly b (0..N/2-1): g = b/h, o = b mod h, rd_addr_a = 2*g*h + o, rd_addr_b = rd_addr_a + h.
REQ-021 tw_idx: NTT = (1<<s) + g; INTT = (N>>(s+1)) + g; always within 1..N-1.
REQ-022 All address arithmetic is in LOGN bits with no overflow for legal parameters; h is derived by shift, not by a multiplier.
REQ-023 rd_en = 1 exactly when state is RUN and valid = 1; b increments only on such cycles.
REQ-024 When rd_en issues b = N/2-1, next state is FLUSH with flush counter = 0.
REQ-025 FLUSH issues no reads and counts LAT valid cycles; it then moves to RUN with stage+1 and b=0, or to DONE if stage = LOGN-1.
REQ-026 No read of stage s+1 issues before every write of stage s has been emitted (RAW hazard closed by FLUSH).
REQ-027 Write pipeline: a LAT-deep shift of {rd_en, rd_addr_a, rd_addr_b}; it shifts only when valid = 1.
REQ-028 wr_en/wr_addr_* equal the rd_en/rd_addr_* issued LAT valid cycles earlier.
REQ-029 With valid held high, each stage takes N/2 + LAT cycles, and the transform takes LOGN*(N/2+LAT) cycles in RUN/FLUSH.
REQ-030 DONE lasts one cycle with done = 1 and busy = 0, then goes to IDLE; start during DONE is ignored.
REQ-031 Outputs are registered except rd_en, which is decoded from state and valid.

Reset
REQ-032 While reset = 1: state IDLE; busy, done, rd_en, wr_en = 0; stage, b, flush counter, all address outputs, tw_idx and pipeline contents = 0.
REQ-033 Reset asserted mid-transform aborts with no further rd_en/wr_en; the next start begins at stage 0.
REQ-034 reset has priority over start and valid in the same cycle.

Verification
REQ-035 LOGN=3, LAT=2, mode=0, valid=1, start pulse -> stage0 pairs (0,4)(1,5)(2,6)(3,7), tw 1,1,1,1; stage1 (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3; stage2 (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7; done exactly 18 cycles after the first rd_en.
REQ-036 Same settings, mode=1 -> stage0 pairs (0,1)..(6,7), tw 4,5,6,7; stage1 (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3; stage2 (0,4)..(3,7), tw 1.
REQ-037 Randomly deassert valid during RUN and FLUSH -> address sequence identical to REQ-035 with gaps; wr_addr always equals the read address from LAT valid cycles earlier; no stage-(s+1) read before the last stage-s write.
REQ-038 Assert reset at stage1, b=2 -> next cycle all outputs 0 and state IDLE; a new start reproduces REQ-035 from stage0.
REQ-039 Pulse start during RUN and during DONE -> ignored; exactly one done pulse per accepted start.
REQ-040 LOGN=12, LAT=8, both modes -> each stage reads every address 0..4095 exactly once; tw_idx never 0 and never above 4095.
